// File: rtl/usb_fs_packet_tx_pkg.sv
// usb_fs_packet_tx_pkg: shared constants, line encodings, states and CRC16 step for the FS packet transmitter
package usb_fs_packet_tx_pkg;
  localparam int CLKS_PER_BIT_DEF = 10;
  localparam int STUFF_LIMIT_DEF = 6;
  localparam logic [7:0] PID_ACK = 8'hD2;
  localparam logic [7:0] PID_NAK = 8'h5A;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [1:0] LINE_J = 2'b10;
  localparam logic [1:0] LINE_K = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;
  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI, ST_EOP_SE0, ST_EOP_J
  } state_t;
  typedef enum logic [1:0] {SYM_BIT, SYM_SE0, SYM_J, SYM_END} sym_t;
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return (crc >> 1) ^ ((crc[0] ^ b) ? CRC16_POLY : 16'h0000);
  endfunction
endpackage

// File: rtl/usb_fs_packet_tx_bit.sv
// usb_tx_bit_engine: bit timing, stuff insertion and NRZI line register
module usb_tx_bit_engine
  import usb_fs_packet_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
  input  logic       useClk,
  input  logic       resetN,
  input  logic       i_start,
  input  logic [1:0] i_sym,
  input  logic       i_bit,
  output logic       o_take,
  output logic       o_oe,
  output logic       o_dp,
  output logic       o_dm
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LIMIT);
  logic [CW-1:0] r_cnt;
  logic [OW-1:0] r_ones;
  logic r_active;
  logic [1:0] r_line;
  logic w_load, w_stuff;
  assign w_load = r_active && r_cnt == CNT_LAST;
  assign w_stuff = w_load && r_ones == ONES_MAX;
  assign o_take = w_load && !w_stuff;
  assign o_oe = r_active;
  assign o_dp = r_line[1];
  assign o_dm = r_line[0];
  // start puts the first SYNC bit (a 0, hence K) on the line in the same edge
  always_ff @(posedge useClk) begin
    if (!resetN) begin
      r_cnt <= '0;
      r_ones <= '0;
      r_active <= 1'b0;
      r_line <= LINE_J;
    end else if (i_start) begin
      r_cnt <= '0;
      r_ones <= '0;
      r_active <= 1'b1;
      r_line <= LINE_K;
    end else if (r_active) begin
      r_cnt <= w_load ? '0 : r_cnt + 1'b1;
      if (w_stuff) begin
        r_line <= ~r_line;
        r_ones <= '0;
      end else if (o_take) begin
        r_line <= i_sym == SYM_BIT ? (i_bit ? r_line : ~r_line) : i_sym == SYM_SE0 ? LINE_SE0 : LINE_J;
        r_ones <= (i_sym == SYM_BIT && i_bit) ? r_ones + 1'b1 : '0;
        r_active <= i_sym != SYM_END;
      end
    end
  end
endmodule

// File: rtl/usb_fs_packet_tx.sv
// usb_fs_packet_tx: full-speed USB packet transmitter (SYNC, PID, data, CRC16, EOP)
module usb_fs_packet_tx
  import usb_fs_packet_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
  input  logic       useClk,
  input  logic       resetN,
  input  logic       txStart,
  input  logic [7:0] txPid,
  input  logic       txHasData,
  input  logic       txCrcEn,
  input  logic [7:0] txData,
  input  logic       txValid,
  input  logic       txLast,
  output logic       txReady,
  output logic       txBusy,
  output logic       txDone,
  output logic       txUnderrun,
  output logic       NRZI,
  output logic       NRZI_not,
  output logic       OE
);
  state_t r_state, w_state_n;
  logic [2:0] r_idx, w_idx_n;
  logic [7:0] r_pid, r_byte;
  logic [15:0] r_crc;
  logic r_last, r_has_data, r_crc_en, r_done;
  logic w_start, w_take, w_bit, w_fetch, w_underrun, w_oe;
  logic [1:0] w_sym;
  assign w_start = txStart && r_state == ST_IDLE;
  // state/idx name the next bit to hand to the engine, not the one on the line
  always_comb begin
    w_bit = 1'b0;
    w_sym = SYM_BIT;
    w_fetch = 1'b0;
    w_underrun = 1'b0;
    w_state_n = r_state;
    w_idx_n = r_idx;
    case (r_state)
      ST_SYNC: w_bit = SYNC_BYTE[r_idx];
      ST_PID: w_bit = r_pid[r_idx];
      ST_DATA: begin
        w_fetch = r_idx == 3'd0;
        w_underrun = w_fetch && !txValid;
        w_bit = w_fetch ? txData[0] : r_byte[r_idx];
        w_sym = w_underrun ? SYM_SE0 : SYM_BIT;
      end
      ST_CRC_LO: w_bit = ~r_crc[{1'b0, r_idx}];
      ST_CRC_HI: w_bit = ~r_crc[{1'b1, r_idx}];
      ST_EOP_SE0: w_sym = SYM_SE0;
      ST_EOP_J: w_sym = r_idx[0] ? SYM_END : SYM_J;
      default: ;
    endcase
    if (w_take) begin
      case (r_state)
        ST_SYNC: w_state_n = &r_idx ? ST_PID : ST_SYNC;
        ST_PID: w_state_n = &r_idx ? (r_has_data ? ST_DATA : r_crc_en ? ST_CRC_LO : ST_EOP_SE0) : ST_PID;
        ST_DATA: w_state_n = w_underrun ? ST_EOP_SE0 : (&r_idx && r_last) ? (r_crc_en ? ST_CRC_LO : ST_EOP_SE0) : ST_DATA;
        ST_CRC_LO: w_state_n = &r_idx ? ST_CRC_HI : ST_CRC_LO;
        ST_CRC_HI: w_state_n = &r_idx ? ST_EOP_SE0 : ST_CRC_HI;
        ST_EOP_SE0: w_state_n = r_idx[0] ? ST_EOP_J : ST_EOP_SE0;
        ST_EOP_J: w_state_n = r_idx[0] ? ST_IDLE : ST_EOP_J;
        default: ;
      endcase
      w_idx_n = w_underrun ? 3'd1 : (w_state_n != r_state) ? 3'd0 : r_idx + 3'd1;
    end
  end
  always_ff @(posedge useClk) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
      r_idx <= 3'd0;
      r_pid <= 8'h00;
      r_byte <= 8'h00;
      r_last <= 1'b0;
      r_has_data <= 1'b0;
      r_crc_en <= 1'b0;
      r_crc <= CRC16_INIT;
      r_done <= 1'b0;
    end else begin
      r_done <= w_take && w_sym == SYM_END;
      if (w_start) begin
        r_state <= ST_SYNC;
        r_idx <= 3'd1;
        r_pid <= txPid;
        r_has_data <= txHasData;
        r_crc_en <= txCrcEn;
        r_crc <= CRC16_INIT;
      end else begin
        r_state <= w_state_n;
        r_idx <= w_idx_n;
        if (txReady) begin
          r_byte <= txData;
          r_last <= txLast;
        end
        if (w_take && r_state == ST_DATA && !w_underrun) r_crc <= crc16_step(r_crc, w_bit);
      end
    end
  end
  usb_tx_bit_engine #(.CLKS_PER_BIT(CLKS_PER_BIT), .STUFF_LIMIT(STUFF_LIMIT)) u_bit (
    .useClk(useClk),
    .resetN(resetN),
    .i_start(w_start),
    .i_sym(w_sym),
    .i_bit(w_bit),
    .o_take(w_take),
    .o_oe(w_oe),
    .o_dp(NRZI),
    .o_dm(NRZI_not)
  );
  assign txReady = w_take && w_fetch && txValid;
  assign txUnderrun = w_take && w_underrun;
  assign txDone = r_done;
  assign txBusy = w_oe;
  assign OE = w_oe;
endmodule

// File: tb/tb_usb_fs_packet_tx.sv
// tb_usb_fs_packet_tx: directed and random packets checked against a bit-level wire model
module tb_usb_fs_packet_tx;
  import usb_fs_packet_tx_pkg::*;
  logic useClk = 1'b0, resetN = 1'b0, txStart = 1'b0, txHasData = 1'b0, txCrcEn = 1'b0;
  logic txValid = 1'b0, txLast = 1'b0;
  logic [7:0] txPid = 8'h00, txData = 8'h00;
  logic txReady, txBusy, txDone, txUnderrun, NRZI, NRZI_not, OE;
  int checks = 0, errors = 0;
  logic [7:0] pay [16];
  logic [1:0] cap [$];
  logic [1:0] exp_sym [$];
  logic [7:0] dec [$];
  int exp_stuffs, dec_stuffs, done_cnt, ready_cnt, und_cnt, busy_bad;
  bit timed_out;

  always #4 useClk = ~useClk;

  usb_fs_packet_tx dut (
    .useClk(useClk), .resetN(resetN), .txStart(txStart), .txPid(txPid),
    .txHasData(txHasData), .txCrcEn(txCrcEn), .txData(txData), .txValid(txValid),
    .txLast(txLast), .txReady(txReady), .txBusy(txBusy), .txDone(txDone),
    .txUnderrun(txUnderrun), .NRZI(NRZI), .NRZI_not(NRZI_not), .OE(OE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // wire model: raw bits, then stuffing, then NRZI, then EOP
  task automatic build_expected(input logic [7:0] pid, input bit has_data, input bit crc_en, input int n, input bit underrun);
    bit raw [$];
    logic [7:0] s = 8'h80;
    logic [7:0] b8;
    logic [15:0] crc = 16'hFFFF;
    logic lvl = 1'b1;
    logic fb;
    int ones = 0;
    for (int i = 0; i < 8; i++) raw.push_back(s[i]);
    for (int i = 0; i < 8; i++) raw.push_back(pid[i]);
    if (has_data)
      for (int k = 0; k < n; k++) begin
        b8 = pay[k];
        for (int i = 0; i < 8; i++) begin
          raw.push_back(b8[i]);
          fb = crc[0] ^ b8[i];
          crc = crc >> 1;
          if (fb) crc = crc ^ 16'hA001;
        end
      end
    if (crc_en && !underrun)
      for (int i = 0; i < 16; i++) raw.push_back(~crc[i]);
    exp_sym.delete();
    exp_stuffs = 0;
    foreach (raw[i]) begin
      if (!raw[i]) lvl = ~lvl;
      exp_sym.push_back({lvl, ~lvl});
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = ~lvl;
        exp_sym.push_back({lvl, ~lvl});
        ones = 0;
        exp_stuffs++;
      end
    end
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b10);
  endtask

  // receiver view of the captured line: mid-bit sample, NRZI decode, unstuff
  task automatic decode();
    bit bits [$];
    logic prev = 1'b1;
    logic b;
    logic [7:0] v;
    int ones = 0;
    dec.delete();
    dec_stuffs = 0;
    for (int k = 0; k * 10 + 5 < cap.size(); k++) begin
      if (cap[k*10+5] == 2'b00) break;
      b = cap[k*10+5][1] == prev;
      prev = cap[k*10+5][1];
      if (ones == 6) begin
        dec_stuffs++;
        ones = 0;
      end else begin
        bits.push_back(b);
        ones = b ? ones + 1 : 0;
      end
    end
    for (int j = 0; j + 8 <= bits.size(); j += 8) begin
      for (int i = 0; i < 8; i++) v[i] = bits[j+i];
      dec.push_back(v);
    end
  endtask

  task automatic drive(input int ptr, input int n, input bit underrun);
    txValid = ptr < n;
    txData = ptr < n ? pay[ptr] : 8'($urandom);
    txLast = (ptr == n - 1) && !underrun;
  endtask

  task automatic run_pkt(input logic [7:0] pid, input bit has_data, input bit crc_en, input int n, input bit underrun, input bit poke);
    int ptr = 0, cyc = 0;
    bit cons, got_done = 0;
    cap.delete();
    done_cnt = 0; ready_cnt = 0; und_cnt = 0; busy_bad = 0;
    @(posedge useClk); #1;
    txPid = pid; txHasData = has_data; txCrcEn = crc_en; txStart = 1'b1;
    drive(ptr, n, underrun);
    @(posedge useClk); #1;
    txStart = 1'b0; txPid = 8'($urandom); txHasData = 1'($urandom); txCrcEn = 1'($urandom);
    while (!got_done && cyc < 3000) begin
      @(negedge useClk);
      cyc++;
      if (OE) cap.push_back({NRZI, NRZI_not});
      if (OE !== txBusy) busy_bad++;
      done_cnt += int'(txDone);
      ready_cnt += int'(txReady);
      und_cnt += int'(txUnderrun);
      got_done = txDone;
      cons = txReady;
      txStart = poke && cap.size() == 50;
      if (txStart) txPid = PID_NAK;
      @(posedge useClk); #1;
      txStart = 1'b0;
      if (cons) ptr++;
      drive(ptr, n, underrun);
    end
    timed_out = !got_done;
    repeat (20) begin
      @(negedge useClk);
      done_cnt += int'(txDone);
      if (OE) busy_bad++;
    end
    build_expected(pid, has_data, crc_en, n, underrun);
    decode();
  endtask

  task automatic check_pkt(input string name, input logic [7:0] pid, input bit has_data, input int n, input bit underrun);
    int mism = 0, pay_bad = 0;
    for (int c = 0; c < cap.size() && c < exp_sym.size() * 10; c++)
      if (cap[c] !== exp_sym[c/10]) mism++;
    for (int i = 0; i < n && has_data; i++)
      if (dec.size() <= 2 + i || dec[2+i] !== pay[i]) pay_bad++;
    chk({name, " timeout"}, 32'(timed_out), 0);
    chk({name, " oe_cycles"}, cap.size(), exp_sym.size() * 10);
    chk({name, " line_mismatch"}, mism, 0);
    chk({name, " done_count"}, done_cnt, 1);
    chk({name, " ready_count"}, ready_cnt, has_data ? n : 0);
    chk({name, " underrun_count"}, und_cnt, 32'(underrun));
    chk({name, " busy_vs_oe"}, busy_bad, 0);
    chk({name, " dec_sync"}, dec.size() > 0 ? dec[0] : 8'hxx, 8'h80);
    chk({name, " dec_pid"}, dec.size() > 1 ? dec[1] : 8'hxx, pid);
    chk({name, " dec_payload"}, pay_bad, 0);
    chk({name, " stuff_count"}, dec_stuffs, exp_stuffs);
  endtask

  initial begin
    int dn;
    repeat (3) @(posedge useClk);
    #1;
    chk("reset OE", OE, 0);
    chk("reset NRZI", NRZI, 1);
    chk("reset NRZI_not", NRZI_not, 0);
    chk("reset busy", txBusy, 0);
    chk("reset done", txDone, 0);
    chk("reset ready", txReady, 0);
    chk("reset underrun", txUnderrun, 0);
    resetN = 1'b1;

    run_pkt(PID_ACK, 0, 0, 0, 0, 1);
    check_pkt("ack", PID_ACK, 0, 0, 0);
    chk("ack oe190", cap.size(), 190);

    pay[0] = 8'h80; pay[1] = 8'h06; pay[2] = 8'h00; pay[3] = 8'h01;
    pay[4] = 8'h00; pay[5] = 8'h00; pay[6] = 8'h40; pay[7] = 8'h00;
    run_pkt(PID_DATA0, 1, 1, 8, 0, 0);
    check_pkt("setup", PID_DATA0, 1, 8, 0);
    chk("setup crc_lo", dec.size() >= 2 ? dec[dec.size()-2] : 8'hxx, 8'hDD);
    chk("setup crc_hi", dec.size() >= 2 ? dec[dec.size()-1] : 8'hxx, 8'h94);

    pay[0] = 8'hFF;
    run_pkt(PID_DATA0, 1, 1, 1, 0, 0);
    check_pkt("stuff", PID_DATA0, 1, 1, 0);

    run_pkt(PID_DATA1, 0, 1, 0, 0, 0);
    check_pkt("zlp", PID_DATA1, 0, 0, 0);
    chk("zlp oe350", cap.size(), 350);
    chk("zlp crc", dec.size() >= 2 ? {dec[dec.size()-2], dec[dec.size()-1]} : 16'hxxxx, 16'h0000);

    pay[0] = 8'h01;
    run_pkt(PID_DATA0, 1, 1, 1, 1, 0);
    check_pkt("underrun", PID_DATA0, 1, 1, 1);

    for (int r = 0; r < 4; r++) begin
      dn = $urandom_range(1, 6);
      for (int i = 0; i < dn; i++) pay[i] = 8'($urandom);
      if (r == 0) pay[0] = 8'hFE;
      run_pkt($urandom_range(0, 1) ? PID_DATA1 : PID_DATA0, 1, 1, dn, 0, 0);
      check_pkt("random", exp_sym.size() > 0 ? dec[1] : 8'h00, 1, dn, 0);
      build_expected(dec.size() > 1 ? dec[1] : 8'h00, 1, 1, dn, 0);
    end

    @(posedge useClk); #1;
    txPid = PID_ACK; txHasData = 1'b0; txCrcEn = 1'b0; txStart = 1'b1;
    @(posedge useClk); #1;
    txStart = 1'b0;
    repeat (110) @(posedge useClk);
    #1 resetN = 1'b0;
    @(posedge useClk); #1;
    resetN = 1'b1;
    chk("midreset OE", OE, 0);
    chk("midreset NRZI", NRZI, 1);
    chk("midreset NRZI_not", NRZI_not, 0);
    chk("midreset busy", txBusy, 0);
    chk("midreset done", txDone, 0);
    dn = 0;
    repeat (300) begin
      @(negedge useClk);
      dn += int'(txDone) + int'(OE);
    end
    chk("midreset quiet", dn, 0);
    run_pkt(PID_ACK, 0, 0, 0, 0, 0);
    check_pkt("ack_after_reset", PID_ACK, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/usb_fs_packet_tx.md
Name: usb_fs_packet_tx

Overview:
Full-speed (12 Mb/s) USB packet transmitter. It is the transmit counterpart of the device's receive path (NRZI decode, unstuff, SYNC/EOP detect). It takes a PID plus an optional byte stream and emits a complete packet on the D+/D- pads: SYNC, PID, data, optional CRC16, and EOP, with bit stuffing and NRZI encoding. It sits between the PID/descriptor response logic and the pad tristate, running on the 120 MHz PLL clock.

Parameters:
CLKS_PER_BIT, 10, useClk cycles per USB bit time (120 MHz / 12 Mb/s).
STUFF_LIMIT, 6, consecutive 1s after which a 0 is inserted.

Ports:
useClk  input  1  120 MHz clock, all logic on rising edge
resetN  input  1  synchronous, active-low reset
txStart  input  1  one-cycle request; accepted only in IDLE
txPid  input  8  full PID byte (check nibble included), latched on accepted txStart
txHasData  input  1  latched with txStart; 1 = data phase follows
txCrcEn  input  1  latched with txStart; 1 = append CRC16 (data packets, including zero-length)
txData  input  8  payload byte
txValid  input  1  txData valid
txLast  input  1  qualifies txData as the final byte
txReady  output  1  one-cycle pulse: txData/txLast consumed this cycle
txBusy  output  1  high from accepted txStart until txDone
txDone  output  1  one-cycle pulse after EOP completes
txUnderrun  output  1  one-cycle pulse: byte needed but txValid low
NRZI  output  1  D+ drive value
NRZI_not  output  1  D- drive value
OE  output  1  pad output enable

Behaviour:
- Reset (resetN=0 at an edge): state IDLE, OE=0, NRZI=1, NRZI_not=0 (J), txReady/txDone/txUnderrun/txBusy=0, CRC=0xFFFF, ones counter=0. Reset mid-packet aborts immediately with no txDone.
- States: IDLE -> SYNC -> PID -> (DATA if txHasData) -> (CRC_LO -> CRC_HI if txCrcEn) -> EOP_SE0 -> EOP_J -> IDLE.
- Latency: txStart seen in IDLE at cycle N -> OE=1, txBusy=1, first SYNC bit on the line from cycle N+1. txStart while busy is ignored.
- Each bit, including stuffed bits, is held exactly CLKS_PER_BIT cycles. All bytes go out LSB first.
- SYNC is 0x80 (bits 0,0,0,0,0,0,0,1) and gives line KJKJKJKK.
- NRZI encoding: a 0 toggles the line, a 1 holds it. The encoder starts from J (NRZI=1). NRZI_not = ~NRZI outside EOP.
- Bit stuffing:
  - The ones counter clears at SYNC start and counts across SYNC, PID, DATA, and CRC.
  - After STUFF_LIMIT consecutive 1s, a 0 bit is inserted and the counter clears. The stuffed bit is not fed to the CRC.
  - Stuffing also applies after the final CRC bit, before EOP.
- DATA byte fetch:
  - Happens in the cycle the previous byte's last bit time ends (PID->DATA transition or DATA->DATA). txValid/txData/txLast are sampled there and txReady pulses for that cycle.
  - txLast=1 on the fetched byte ends the DATA state after that byte.
- Underrun: txValid=0 at a fetch point -> txUnderrun pulse, CRC skipped, go directly to EOP_SE0. This yields a corrupted packet, by design.
- CRC16 (reflected form):
  - Init 0xFFFF.
  - Per data bit b: fb = crc[0]^b; crc = crc>>1; if fb, crc ^= 0xA001.
  - Transmitted as ~crc, low byte then high byte, LSB first.
  - A zero-length payload gives wire bytes 0x00 0x00.
- EOP:
  - SE0 (NRZI=0, NRZI_not=0) for 2 bit times, then J (1,0) for 1 bit time.
  - Then OE=0 and txBusy=0; txDone pulses on that same cycle, and the state returns to IDLE.
- PID-only packet duration: (8+8+3)*CLKS_PER_BIT cycles with OE high, plus CLKS_PER_BIT per stuffed bit and per data/CRC byte bit.

Decomposition:
- Shared package holds:
  - PID constants (ACK 0xD2, NAK 0x5A, DATA0 0xC3, DATA1 0x4B)
  - SYNC byte 0x80
  - CRC16 init 0xFFFF and polynomial 0xA001
  - J/K/SE0 line encodings
  - the state enum
- One sub-module, usb_tx_bit_engine, is natural. It owns the bit-time counter, the ones counter, stuff insertion, and the NRZI register. It takes a bit plus a "next bit" strobe from the byte-level FSM.

Test Plan:
- ACK: txStart, txPid=0xD2, txHasData=0 -> NRZI per bit 0,1,0,1,0,1,0,0 | 1,1,0,1,1,0,0,0, then SE0 2 bits, J 1 bit. OE high exactly 190 cycles, txDone once, txReady never.
- Setup payload: DATA0 0xC3 with bytes 80 06 00 01 00 00 40 00, txCrcEn=1 -> decoded wire bytes end DD 94. Eight txReady pulses, txDone once.
- Stuffing: DATA0 with a single byte 0xFF, txLast=1 -> exactly one stuffed 0 after the 4th data bit. 0xFF is fed to the CRC unstuffed. OE duration includes +10 cycles per stuffed bit.
- Zero-length DATA1 (0x4B), txHasData=0, txCrcEn=1 -> CRC wire bytes 0x00 0x00. Total 35 bit times, assuming no stuffing.
- Underrun: DATA0 with byte 0x01, then txValid low at the next fetch -> txUnderrun pulse, no CRC, EOP follows immediately, txDone pulses.
- Reset mid-PID: resetN=0 for 1 cycle -> the next cycle shows OE=0, NRZI=1, NRZI_not=0, txBusy=0, and no txDone. A new txStart then produces a clean ACK.
